// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the external SRAM data-memory controller
// Contents: controller state enum, default parameter values, SRAM data width, wait counter width.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 4;
  localparam int unsigned DEF_SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - 4-bit down-counter with load, decrement and zero flag
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   load, load_val : load takes priority over decrement
//   dec            : decrement, saturates at zero
//   zero           : count equals zero
module wait_counter
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - MEM-stage 32-bit load/store controller for a 16-bit asynchronous SRAM
// Each request becomes two half-word accesses (low then high), each held WAIT_CYCLES cycles.
// Optional feature macro: SRAM_CTRL_RANGE_CHECK_EN (out-of-range requests finish at once and set addr_err).
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   rd_en, wr_en             : load / store request (both set = store)
//   address, write_data      : byte address and store data, held stable while ready is low
//   read_data                : last loaded word
//   ready                    : low while a request is in flight
//   sram_addr, sram_dq_out,
//   sram_dq_in, sram_dq_oe,
//   sram_we_n                : SRAM pad interface
//   addr_err                 : sticky out-of-range flag (range-check build only)
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DW-1:0]     sram_dq_out,
  input  logic [SRAM_DW-1:0]     sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  ,
  output logic                   addr_err
`endif
);

  localparam logic [31:0]      BASE      = 32'(BASE_ADDR);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam int unsigned      WORD_W    = SRAM_ADDR_W - 1;

  state_e              state_q, state_d;
  logic                wr_op_q, wr_op_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         read_data_q, read_data_d;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [31:0]         word_full;
  logic                unused_word;

  // Byte offset from the SRAM window base; the word index is this shifted right by 2.
  assign word_full   = address - BASE;
  assign unused_word = ^{word_full[31:SRAM_ADDR_W+1], word_full[1:0]};

`ifdef SRAM_CTRL_RANGE_CHECK_EN
  logic err_q, err_d;
  logic out_of_range;
  // A word index at or above 2^WORD_W needs a nonzero bit above word_full[SRAM_ADDR_W].
  assign out_of_range = (address < BASE) || (word_full[31:SRAM_ADDR_W+1] != '0);
  assign addr_err     = err_q;
`endif

  wait_counter u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    wr_op_d     = wr_op_q;
    word_d      = word_q;
    read_data_d = read_data_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          wr_op_d = wr_en;
          word_d  = word_full[SRAM_ADDR_W:2];
`ifdef SRAM_CTRL_RANGE_CHECK_EN
          if (out_of_range) begin
            state_d     = ST_DONE;
            read_data_d = '0;
            err_d       = 1'b1;
          end else begin
            state_d  = ST_LO;
            cnt_load = 1'b1;
          end
`else
          state_d  = ST_LO;
          cnt_load = 1'b1;
`endif
        end
      end

      ST_LO, ST_HI: begin
        sram_addr = {word_q, (state_q == ST_HI)};
        if (wr_op_q) begin
          sram_dq_out = (state_q == ST_HI) ? write_data[31:16] : write_data[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (cnt_zero) begin
          // Read data is taken at the end of the hold window, after the SRAM access time.
          if (!wr_op_q) begin
            if (state_q == ST_HI) begin
              read_data_d[31:16] = sram_dq_in;
            end else begin
              read_data_d[15:0] = sram_dq_in;
            end
          end
          cnt_load = 1'b1;
          state_d  = (state_q == ST_HI) ? ST_DONE : ST_HI;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_op_q     <= 1'b0;
      word_q      <= '0;
      read_data_q <= '0;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_op_q     <= wr_op_d;
      word_q      <= word_d;
      read_data_q <= read_data_d;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign read_data = read_data_q;
  assign ready     = ~(rd_en | wr_en) | (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl (default and WAIT_CYCLES=1 instances)
module tb_sram_ctrl;

  logic        clk;
  logic        rst;

  logic        rd_en1, wr_en1;
  logic [31:0] address1, write_data1, read_data1;
  logic        ready1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1, dq_in1;
  logic        oe1, we_n1;

  logic        rd_en2, wr_en2;
  logic [31:0] address2, write_data2, read_data2;
  logic        ready2;
  logic [17:0] sram_addr2;
  logic [15:0] dq_out2, dq_in2;
  logic        oe2, we_n2;

`ifdef SRAM_CTRL_RANGE_CHECK_EN
  logic        addr_err1, addr_err2;
`endif

  sram_ctrl dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
    .sram_dq_oe(oe1), .sram_we_n(we_n1)
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    , .addr_err(addr_err1)
`endif
  );

  sram_ctrl #(.WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd_en2), .wr_en(wr_en2), .address(address2),
    .write_data(write_data2), .read_data(read_data2), .ready(ready2),
    .sram_addr(sram_addr2), .sram_dq_out(dq_out2), .sram_dq_in(dq_in2),
    .sram_dq_oe(oe2), .sram_we_n(we_n2)
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    , .addr_err(addr_err2)
`endif
  );

  // Behavioural asynchronous SRAMs: write on strobe, combinational read.
  logic [15:0] sram1 [0:255];
  logic [15:0] sram2 [0:255];
  assign dq_in1 = sram1[sram_addr1[7:0]];
  assign dq_in2 = sram2[sram_addr2[7:0]];
  always @(posedge clk) if (!we_n1) sram1[sram_addr1[7:0]] <= dq_out1;
  always @(posedge clk) if (!we_n2) sram2[sram_addr2[7:0]] <= dq_out2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          passes = 0;

  // Reference model: 32-bit words indexed by (address-1024)/4, plus the last loaded value.
  logic [31:0] ref_mem [0:63];
  logic [31:0] last_rd;

  int          lat, lo_pulses, hi_pulses, we_low;
  logic [15:0] lo_dat, hi_dat;
  logic [17:0] lo_addr, hi_addr;
  logic [31:0] rd_at_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called just after a rising edge; the current cycle is cycle 0 of the request.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    lat = -1; lo_pulses = 0; hi_pulses = 0; we_low = 0;
    lo_dat = '0; hi_dat = '0; lo_addr = '1; hi_addr = '1; rd_at_ready = 'x;
    rd_en1 = rd; wr_en1 = wr; address1 = a; write_data1 = d;
    for (int c = 0; c < 64 && lat < 0; c++) begin
      @(negedge clk);
      if (!we_n1) begin
        we_low++;
        if (sram_addr1[0]) begin hi_pulses++; hi_dat = dq_out1; hi_addr = sram_addr1; end
        else begin lo_pulses++; lo_dat = dq_out1; lo_addr = sram_addr1; end
      end
      if (ready1) begin lat = c; rd_at_ready = read_data1; end
    end
    @(posedge clk); #1;
    rd_en1 = 1'b0; wr_en1 = 1'b0;
  endtask

  initial begin
    logic [7:0]  rmask;
    logic [31:0] da, db, rdata;
    int          w;
    logic        is_wr;

    for (int i = 0; i < 256; i++) begin sram1[i] = '0; sram2[i] = '0; end
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    last_rd = '0;
    rst = 1'b0;
    rd_en1 = 0; wr_en1 = 0; address1 = '0; write_data1 = '0;
    rd_en2 = 0; wr_en2 = 0; address2 = '0; write_data2 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", read_data1, 32'h0);
    check("rst_sram_addr", 32'(sram_addr1), 32'h0);
    check("rst_dq_out", 32'(dq_out1), 32'h0);
    check("rst_oe", 32'(oe1), 32'h0);
    check("rst_we_n", 32'(we_n1), 32'h1);
    check("rst_ready_idle", 32'(ready1), 32'h1);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    check("rst_addr_err", 32'(addr_err1), 32'h0);
`endif
    rd_en1 = 1'b1; #1;
    check("rst_ready_req", 32'(ready1), 32'h0);
    rd_en1 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Write 0xDEADBEEF to 1028
    do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    ref_mem[1] = 32'hDEADBEEF;
    check("wr_latency", 32'(lat), 32'd9);
    check("wr_lo_pulses", 32'(lo_pulses), 32'd4);
    check("wr_hi_pulses", 32'(hi_pulses), 32'd4);
    check("wr_lo_addr", 32'(lo_addr), 32'd2);
    check("wr_hi_addr", 32'(hi_addr), 32'd3);
    check("wr_lo_data", 32'(lo_dat), 32'hBEEF);
    check("wr_hi_data", 32'(hi_dat), 32'hDEAD);
    check("wr_rd_unchanged", rd_at_ready, last_rd);

    // Read it back
    do_req(1'b1, 1'b0, 32'd1028, 32'h0);
    last_rd = ref_mem[1];
    check("rd_latency", 32'(lat), 32'd9);
    check("rd_data", rd_at_ready, 32'hDEADBEEF);
    check("rd_no_we", 32'(we_low), 32'd0);

    // Both enables: treated as a write
    do_req(1'b1, 1'b1, 32'd1024, 32'h12345678);
    ref_mem[0] = 32'h12345678;
    check("both_latency", 32'(lat), 32'd9);
    check("both_is_write", 32'(lo_pulses + hi_pulses), 32'd8);
    check("both_rd_unchanged", rd_at_ready, last_rd);
    do_req(1'b1, 1'b0, 32'd1024, 32'h0);
    last_rd = ref_mem[0];
    check("both_readback", rd_at_ready, 32'h12345678);

    // Randomized back-to-back traffic against the word-level model
    for (int n = 0; n < 24; n++) begin
      w     = $urandom_range(0, 31);
      is_wr = 1'($urandom_range(0, 1));
      rdata = $urandom;
      do_req(~is_wr, is_wr, 32'(1024 + 4 * w), rdata);
      if (is_wr) ref_mem[w] = rdata;
      else last_rd = ref_mem[w];
      check("rand_latency", 32'(lat), 32'd9);
      check(is_wr ? "rand_wr_rd_hold" : "rand_rd_data", rd_at_ready, last_rd);
    end

    // Reset in cycle 5 of a write to word 40
    rd_en1 = 1'b0; wr_en1 = 1'b1; address1 = 32'(1024 + 160); write_data1 = $urandom;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0; wr_en1 = 1'b0;
    @(negedge clk);
    check("rstmid_we_n", 32'(we_n1), 32'h1);
    check("rstmid_oe", 32'(oe1), 32'h0);
    check("rstmid_read_data", read_data1, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    last_rd = '0;
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 32'd1028, 32'h0);
    last_rd = ref_mem[1];
    check("rstmid_next_latency", 32'(lat), 32'd9);
    check("rstmid_next_data", rd_at_ready, last_rd);

    // WAIT_CYCLES=1: two back-to-back writes, ready in cycles 3 and 7
    da = $urandom; db = $urandom;
    rmask = '0;
    wr_en2 = 1'b1; address2 = 32'd1024; write_data2 = da;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rmask[c] = ready2;
      if (c == 3) begin
        @(posedge clk); #1;
        address2 = 32'd1028; write_data2 = db;
      end
    end
    @(posedge clk); #1 wr_en2 = 1'b0;
    check("w1_ready_cycles", 32'(rmask), 32'h88);
    check("w1_word0", {sram2[1], sram2[0]}, da);
    check("w1_word1", {sram2[3], sram2[2]}, db);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    do_req(1'b1, 1'b0, 32'd512, 32'h0);
    check("oor_latency", 32'(lat), 32'd1);
    check("oor_read_data", rd_at_ready, 32'h0);
    check("oor_no_strobe", 32'(we_low), 32'd0);
    check("oor_addr_err", 32'(addr_err1), 32'h1);
    do_req(1'b1, 1'b0, 32'd1028, 32'h0);
    check("oor_valid_latency", 32'(lat), 32'd9);
    check("oor_valid_data", rd_at_ready, ref_mem[1]);
    check("oor_err_sticky", 32'(addr_err1), 32'h1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Data-memory controller that replaces the on-chip register-array memory in the MEM stage with an external 16-bit asynchronous SRAM. It accepts one 32-bit load or store per request from the EXE/MEM pipeline register. It splits each request into two 16-bit SRAM half-word accesses, each held for a programmable number of wait cycles. While busy it drops `ready`, which the hazard/freeze logic uses to stall every pipeline register upstream of MEM/WB.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 4: cycles each half-word access is held on the SRAM bus; legal range 1..15.
- `SRAM_ADDR_W`, 18: SRAM half-word address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `rd_en` input 1: load request (memRead from EXE/MEM).
- `wr_en` input 1: store request (memWrite from EXE/MEM).
- `address` input 32: byte address from ALU result.
- `write_data` input 32: store data (Val_Rm).
- `read_data` output 32: load result to MEM/WB.
- `ready` output 1: high when no request is pending or the current request has completed.
- `sram_addr` output SRAM_ADDR_W: half-word address.
- `sram_dq_out` output 16: write data driven to the pad.
- `sram_dq_in` input 16: read data from the pad.
- `sram_dq_oe` output 1: pad output enable.
- `sram_we_n` output 1: SRAM write strobe, active-low.
- `addr_err` output 1: sticky out-of-range flag; present only with the range-check feature.

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If `rd_en|wr_en`, latch the op and compute `word = (address - BASE_ADDR) >> 2`, 32-bit subtract.
  - Go to LO and load the wait counter with WAIT_CYCLES-1.
  - If both enables are set, treat the request as a write.
- LO:
  - `sram_addr = {word[SRAM_ADDR_W-2:0],1'b0}`.
  - Write: `sram_dq_out = write_data[15:0]`, `sram_dq_oe=1`, `sram_we_n=0`.
  - Read: `sram_dq_oe=0`, `sram_we_n=1`, and `sram_dq_in` is captured into `read_data[15:0]` on the cycle the counter reaches 0.
  - Counter reaching 0 → HI, counter reloaded.
- HI: same as LO with address LSB = 1 and data bits [31:16]; counter reaching 0 → DONE.
- DONE: `ready=1` for exactly one cycle, then IDLE.
- `ready` is combinational: `ready = ~(rd_en|wr_en) | (state==DONE)`.
- `read_data`:
  - Holds its last loaded value and updates only during read phases.
  - A write does not modify it.
- `address` and `write_data` must be held stable while `ready=0`; the pipeline freeze guarantees this. The block samples `address` only in IDLE and `write_data` each phase.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `read_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`, `addr_err=0`.
  - `ready = ~(rd_en|wr_en)`.
- Request latency: a request first visible in cycle 0 produces `ready=1` in cycle 2·WAIT_CYCLES+1, which is cycle 9 for the default.
- Back-to-back requests: DONE→IDLE costs one cycle. The next request starts in IDLE the cycle after DONE, so throughput is one request per 2·WAIT_CYCLES+2 cycles.
- `sram_we_n` deasserts in IDLE and DONE, giving address/data hold around every write pulse boundary between requests.
- Reset mid-request aborts immediately to IDLE with the bus released. A half-written SRAM word is acceptable.
- Enables dropping mid-request (illegal under freeze): the FSM completes the latched op anyway.

## Configuration
- `SRAM_CTRL_RANGE_CHECK_EN` defined:
  - A request with `address < BASE_ADDR` or `word >= 2^(SRAM_ADDR_W-1)` goes IDLE→DONE directly.
  - No SRAM strobes are issued, `read_data` is set to 0, and `addr_err` is set and stays set until reset.
  - Latency is 1 cycle.
- Not defined: no check, `addr_err` port absent, and `word` is truncated to SRAM_ADDR_W-1 bits, so it wraps.

## Structure
- Shared package `sram_ctrl_pkg`:
  - state enum (IDLE/LO/HI/DONE).
  - default `BASE_ADDR`, `WAIT_CYCLES`, `SRAM_ADDR_W` constants.
  - SRAM data width constant (16).
- Sub-module `wait_counter`: 4-bit down-counter with load, decrement, and zero flag.

## Test plan
- Reset, then a write of 0xDEADBEEF to address 1028:
  - `ready` low cycles 0–8, high cycle 9.
  - Write pulses at `sram_addr` 2 (0xBEEF) and 3 (0xDEAD), 4 cycles each.
- Read of 1028 after that write → `read_data=0xDEADBEEF` in the `ready` cycle, and `sram_we_n` stays 1 throughout.
- Both enables set, address 1024, data 0x12345678 → treated as a write. A subsequent read returns 0x12345678 and `read_data` is unchanged by the write itself.
- `rst` asserted in cycle 5 of a write → next cycle state IDLE, `sram_we_n=1`, `sram_dq_oe=0`, `read_data=0`.
- With `SRAM_CTRL_RANGE_CHECK_EN`: read of address 512 → `ready` in cycle 1, `read_data=0`, `addr_err=1` and still 1 after a later valid access.
- `WAIT_CYCLES=1`: two back-to-back writes → `ready` high cycles 3 and 7.
